// File: rtl/tri_scom_reg_access_if.sv
// SCOM satellite and register-bank signal bundle for tri_scom_reg_access.
// The controller uses the slave modport; the satellite/bank model uses master.
interface tri_scom_reg_access_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int ADDR_SIZE  = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  sc_req;
    logic                  sc_r_nw;
    logic [0:ADDR_WIDTH-1] sc_addr;
    logic [0:DATA_WIDTH-1] sc_wdata;
    logic                  sc_busy;
    logic                  sc_ack;
    logic [0:DATA_WIDTH-1] sc_rdata;
    logic [0:2]            sc_err;
    logic [0:ADDR_SIZE-1]  reg_rd_dec;
    logic [0:ADDR_SIZE-1]  reg_wr_dec;
    logic [0:DATA_WIDTH-1] reg_wdata;
    logic                  reg_ack;
    logic [0:DATA_WIDTH-1] reg_rdata;

    modport slave (
        input  sc_req, sc_r_nw, sc_addr, sc_wdata, reg_ack, reg_rdata,
        output sc_busy, sc_ack, sc_rdata, sc_err, reg_rd_dec, reg_wr_dec, reg_wdata
    );

    modport master (
        output sc_req, sc_r_nw, sc_addr, sc_wdata, reg_ack, reg_rdata,
        input  sc_busy, sc_ack, sc_rdata, sc_err, reg_rd_dec, reg_wr_dec, reg_wdata
    );
endinterface

// File: rtl/tri_scom_reg_access.sv
// Registered SCOM register-access controller: captures a request, checks legality,
// strobes the local register bank with a timeout, and returns a one-cycle response.
module tri_scom_reg_access #(
    parameter int                   ADDR_WIDTH     = 6,
    parameter int                   ADDR_SIZE      = 64,
    parameter int                   DATA_WIDTH     = 64,
    parameter logic [0:ADDR_SIZE-1] USE_ADDR       = {1'b1, {(ADDR_SIZE-1){1'b0}}},
    parameter logic [0:ADDR_SIZE-1] ADDR_IS_RDABLE = {1'b1, {(ADDR_SIZE-1){1'b0}}},
    parameter logic [0:ADDR_SIZE-1] ADDR_IS_WRABLE = {1'b1, {(ADDR_SIZE-1){1'b0}}},
    parameter int                   TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    tri_scom_reg_access_if.slave         bus,
    inout  wire                          vd,
    inout  wire                          gd
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic       TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Power rails are carried for netlist compatibility only.
    wire unused_rails_s = vd ^ gd;

    function automatic logic [0:ADDR_SIZE-1] onehot(input logic [0:ADDR_WIDTH-1] a);
        logic [0:ADDR_SIZE-1] v;
        v = {ADDR_SIZE{1'b0}};
        for (int i = 0; i < ADDR_SIZE; i++) begin
            v[i] = (a == ADDR_WIDTH'(i));
        end
        return v;
    endfunction

    // Out-of-range addresses match no mask position and therefore read as 0.
    function automatic logic mask_bit(input logic [0:ADDR_SIZE-1] mask,
                                      input logic [0:ADDR_WIDTH-1] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < ADDR_SIZE; i++) begin
            hit = hit | (mask[i] & (a == ADDR_WIDTH'(i)));
        end
        return hit;
    endfunction

    state_t                state_r, state_s;
    logic [0:ADDR_WIDTH-1] addr_r, addr_s;
    logic                  r_nw_r, r_nw_s;
    logic [0:DATA_WIDTH-1] wdata_r, wdata_s;
    logic [7:0]            cnt_r, cnt_s;
    logic                  busy_r, busy_s;
    logic                  ack_r, ack_s;
    logic [0:DATA_WIDTH-1] rdata_r, rdata_s;
    logic [0:2]            err_r, err_s;
    logic [0:ADDR_SIZE-1]  rd_dec_r, rd_dec_s;
    logic [0:ADDR_SIZE-1]  wr_dec_r, wr_dec_s;

    logic                  addr_nvld_s;
    logic                  perm_nvld_s;
    logic [0:ADDR_SIZE-1]  hot_s;

    assign hot_s       = onehot(addr_r);
    assign addr_nvld_s = ~mask_bit(USE_ADDR, addr_r);
    assign perm_nvld_s = ~addr_nvld_s &
                         (r_nw_r ? ~mask_bit(ADDR_IS_RDABLE, addr_r)
                                 : ~mask_bit(ADDR_IS_WRABLE, addr_r));

    // Next state plus next values of every registered output.
    always_comb begin
        state_s  = state_r;
        addr_s   = addr_r;
        r_nw_s   = r_nw_r;
        wdata_s  = wdata_r;
        cnt_s    = cnt_r;
        busy_s   = 1'b0;
        ack_s    = 1'b0;
        rdata_s  = {DATA_WIDTH{1'b0}};
        err_s    = 3'b000;
        rd_dec_s = {ADDR_SIZE{1'b0}};
        wr_dec_s = {ADDR_SIZE{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (bus.sc_req) begin
                    addr_s  = bus.sc_addr;
                    r_nw_s  = bus.sc_r_nw;
                    wdata_s = bus.sc_wdata;
                    state_s = ST_CHECK;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                busy_s = 1'b1;
                if (addr_nvld_s) begin
                    state_s = ST_RESP;
                    ack_s   = 1'b1;
                    err_s   = 3'b100;
                end else if (perm_nvld_s) begin
                    state_s = ST_RESP;
                    ack_s   = 1'b1;
                    err_s   = 3'b010;
                end else begin
                    state_s = ST_ACCESS;
                    cnt_s   = 8'd0;
                    if (r_nw_r) begin
                        rd_dec_s = hot_s;
                    end else begin
                        wr_dec_s = hot_s;
                    end
                end
            end
            ST_ACCESS: begin
                busy_s = 1'b1;
                // An ack arriving on the final allowed cycle beats the timeout.
                if (bus.reg_ack) begin
                    state_s = ST_RESP;
                    ack_s   = 1'b1;
                    if (r_nw_r) begin
                        rdata_s = bus.reg_rdata;
                    end else begin
                        rdata_s = {DATA_WIDTH{1'b0}};
                    end
                end else if (TO_EN && (cnt_r == TO_LAST)) begin
                    state_s = ST_RESP;
                    ack_s   = 1'b1;
                    err_s   = 3'b001;
                end else begin
                    cnt_s    = cnt_r + 8'd1;
                    rd_dec_s = rd_dec_r;
                    wr_dec_s = wr_dec_r;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latches and output registers; rst clears all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            r_nw_r   <= 1'b0;
            wdata_r  <= {DATA_WIDTH{1'b0}};
            cnt_r    <= 8'd0;
            busy_r   <= 1'b0;
            ack_r    <= 1'b0;
            rdata_r  <= {DATA_WIDTH{1'b0}};
            err_r    <= 3'b000;
            rd_dec_r <= {ADDR_SIZE{1'b0}};
            wr_dec_r <= {ADDR_SIZE{1'b0}};
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            r_nw_r   <= r_nw_s;
            wdata_r  <= wdata_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            ack_r    <= ack_s;
            rdata_r  <= rdata_s;
            err_r    <= err_s;
            rd_dec_r <= rd_dec_s;
            wr_dec_r <= wr_dec_s;
        end
    end

    assign bus.sc_busy    = busy_r;
    assign bus.sc_ack     = ack_r;
    assign bus.sc_rdata   = rdata_r;
    assign bus.sc_err     = err_r;
    assign bus.reg_rd_dec = rd_dec_r;
    assign bus.reg_wr_dec = wr_dec_r;
    assign bus.reg_wdata  = wdata_r;

endmodule

// File: tb/tb_tri_scom_reg_access.sv
// Bench for tri_scom_reg_access: two configurations (40 addresses/timeout 4 and
// 64 addresses/no timeout) driven with directed and random requests against a model.
module tb_tri_scom_reg_access;

    localparam int AW     = 6;
    localparam int DW     = 64;
    localparam int SIZE_A = 40;
    localparam int SIZE_B = 64;
    localparam int TO_A   = 4;
    localparam int TO_B   = 0;

    localparam logic [0:63] USE_M = 64'hFFFB_FFFF_FFDF_FFFF;
    localparam logic [0:63] RD_M  = 64'hFF7A_F0FF_3FFF_0FFF;
    localparam logic [0:63] WR_M  = 64'hFEC5_FF0F_F3FF_FFF0;

    localparam logic [0:SIZE_A-1] USE_A = USE_M[0:SIZE_A-1];
    localparam logic [0:SIZE_A-1] RD_A  = RD_M[0:SIZE_A-1];
    localparam logic [0:SIZE_A-1] WR_A  = WR_M[0:SIZE_A-1];

    logic          clk = 1'b0;
    logic          rst;
    logic          sel_b;
    logic          req;
    logic          r_nw;
    logic [0:AW-1] addr;
    logic [0:DW-1] wdata;
    logic          reg_ack;
    logic [0:DW-1] reg_rdata;
    wire           vd;
    wire           gd;

    int checks = 0;
    int errors = 0;

    assign vd = 1'b1;
    assign gd = 1'b0;

    always #5 clk = ~clk;

    tri_scom_reg_access_if #(.ADDR_WIDTH(AW), .ADDR_SIZE(SIZE_A), .DATA_WIDTH(DW)) bus_a ();
    tri_scom_reg_access_if #(.ADDR_WIDTH(AW), .ADDR_SIZE(SIZE_B), .DATA_WIDTH(DW)) bus_b ();

    assign bus_a.sc_req    = req & ~sel_b;
    assign bus_a.sc_r_nw   = r_nw;
    assign bus_a.sc_addr   = addr;
    assign bus_a.sc_wdata  = wdata;
    assign bus_a.reg_ack   = reg_ack;
    assign bus_a.reg_rdata = reg_rdata;
    assign bus_b.sc_req    = req & sel_b;
    assign bus_b.sc_r_nw   = r_nw;
    assign bus_b.sc_addr   = addr;
    assign bus_b.sc_wdata  = wdata;
    assign bus_b.reg_ack   = reg_ack;
    assign bus_b.reg_rdata = reg_rdata;

    tri_scom_reg_access #(
        .ADDR_WIDTH(AW), .ADDR_SIZE(SIZE_A), .DATA_WIDTH(DW),
        .USE_ADDR(USE_A), .ADDR_IS_RDABLE(RD_A), .ADDR_IS_WRABLE(WR_A),
        .TIMEOUT_CYCLES(TO_A)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a), .vd(vd), .gd(gd));

    tri_scom_reg_access #(
        .ADDR_WIDTH(AW), .ADDR_SIZE(SIZE_B), .DATA_WIDTH(DW),
        .USE_ADDR(USE_M), .ADDR_IS_RDABLE(RD_M), .ADDR_IS_WRABLE(WR_M),
        .TIMEOUT_CYCLES(TO_B)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b), .vd(vd), .gd(gd));

    logic          obs_busy;
    logic          obs_ack;
    logic [0:DW-1] obs_rdata;
    logic [0:DW-1] obs_wdata;
    logic [0:2]    obs_err;
    logic [0:63]   obs_rd;
    logic [0:63]   obs_wr;

    // Present the selected instance's outputs on one set of observation signals.
    always_comb begin
        obs_rd = 64'd0;
        obs_wr = 64'd0;
        if (sel_b) begin
            obs_busy  = bus_b.sc_busy;
            obs_ack   = bus_b.sc_ack;
            obs_rdata = bus_b.sc_rdata;
            obs_wdata = bus_b.reg_wdata;
            obs_err   = bus_b.sc_err;
            obs_rd    = bus_b.reg_rd_dec;
            obs_wr    = bus_b.reg_wr_dec;
        end else begin
            obs_busy  = bus_a.sc_busy;
            obs_ack   = bus_a.sc_ack;
            obs_rdata = bus_a.sc_rdata;
            obs_wdata = bus_a.reg_wdata;
            obs_err   = bus_a.sc_err;
            obs_rd[0:SIZE_A-1] = bus_a.reg_rd_dec;
            obs_wr[0:SIZE_A-1] = bus_a.reg_wr_dec;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request; k = ACCESS cycle carrying reg_ack (0 = never), noise = stray ack in CHECK.
    task automatic run_txn(input bit b, input logic [5:0] a, input bit rd,
                           input logic [63:0] wd, input logic [63:0] rdd,
                           input int k, input bit hold, input bit noise);
        int          size, tmo, acc, ack_exp, n_ack, ack_seen, rd_cyc, wr_cyc;
        int          exp_rd, exp_wr;
        bit          legal, shape_ok, quiet_ok, wd_ok, busy1, end_busy;
        logic [0:2]  err_exp, got_err;
        logic [63:0] rdata_exp, got_rdata;
        logic [0:63] hot;

        size = b ? SIZE_B : SIZE_A;
        tmo  = b ? TO_B : TO_A;
        if (int'(a) >= size || !USE_M[a]) begin
            err_exp = 3'b100;
        end else if (rd ? !RD_M[a] : !WR_M[a]) begin
            err_exp = 3'b010;
        end else begin
            err_exp = 3'b000;
        end
        legal = (err_exp == 3'b000);
        acc = 0;
        if (legal) begin
            if (tmo != 0 && (k == 0 || k > tmo)) begin
                acc     = tmo;
                err_exp = 3'b001;
            end else begin
                acc = k;
            end
        end
        ack_exp   = legal ? 2 + acc : 2;
        rdata_exp = (rd && err_exp == 3'b000) ? rdd : 64'd0;
        exp_rd    = (legal && rd) ? acc : 0;
        exp_wr    = (legal && !rd) ? acc : 0;
        hot       = 64'd0;
        hot[a]    = 1'b1;

        sel_b = b; r_nw = rd; addr = a; wdata = wd; reg_rdata = rdd;
        req = 1'b1; reg_ack = 1'b0;
        n_ack = 0; ack_seen = -1; rd_cyc = 0; wr_cyc = 0;
        shape_ok = 1'b1; quiet_ok = 1'b1; wd_ok = 1'b1; busy1 = 1'b0; end_busy = 1'b1;
        got_err = 3'b111; got_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 1; c <= ack_exp + 1; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = obs_busy;
            if (c == ack_exp + 1) end_busy = obs_busy;
            if (obs_ack) begin
                n_ack++;
                if (ack_seen < 0) ack_seen = c;
                got_err   = obs_err;
                got_rdata = obs_rdata;
            end else if (obs_err != 3'b000 || obs_rdata != 64'd0) begin
                quiet_ok = 1'b0;
            end
            if (obs_rd != 64'd0) begin
                rd_cyc++;
                if (obs_rd != hot) shape_ok = 1'b0;
            end
            if (obs_wr != 64'd0) begin
                wr_cyc++;
                if (obs_wr != hot) shape_ok = 1'b0;
                if (obs_wdata != wd) wd_ok = 1'b0;
            end
            reg_ack = (k != 0 && c == 1 + k) || (noise && c == 1);
            if (!hold || c == ack_exp + 1) req = 1'b0;
        end
        reg_ack = 1'b0;
        chk("busy_after_req", 64'(busy1), 64'd1);
        chk("ack_count", 64'(n_ack), 64'd1);
        chk("ack_cycle", 64'(ack_seen), 64'(ack_exp));
        chk("sc_err", 64'(got_err), 64'(err_exp));
        chk("sc_rdata", got_rdata, rdata_exp);
        chk("rd_dec_cycles", 64'(rd_cyc), 64'(exp_rd));
        chk("wr_dec_cycles", 64'(wr_cyc), 64'(exp_wr));
        chk("dec_onehot", 64'(shape_ok), 64'd1);
        chk("quiet_outside_resp", 64'(quiet_ok), 64'd1);
        chk("reg_wdata", 64'(wd_ok), 64'd1);
        chk("idle_after_resp", 64'(end_busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:63] hot3;
        rst = 1'b1; sel_b = 1'b0; req = 1'b0; r_nw = 1'b0; addr = 6'd0;
        wdata = 64'd0; reg_ack = 1'b0; reg_rdata = 64'd0;
        repeat (3) @(negedge clk);
        chk("rst_a_busy", 64'(bus_a.sc_busy), 64'd0);
        chk("rst_a_ack", 64'(bus_a.sc_ack), 64'd0);
        chk("rst_a_dec", 64'(bus_a.reg_rd_dec | bus_a.reg_wr_dec), 64'd0);
        chk("rst_b_outs", 64'(bus_b.sc_busy | bus_b.sc_ack) | 64'(bus_b.sc_err) | bus_b.sc_rdata, 64'd0);
        chk("rst_b_wdata", bus_b.reg_wdata, 64'd0);
        rst = 1'b0;

        // Directed cases.
        run_txn(1'b0, 6'h05, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd0, 1, 1'b0, 1'b0);
        run_txn(1'b0, 6'h03, 1'b1, 64'd0, 64'h1234, 4, 1'b0, 1'b0);
        run_txn(1'b0, 6'h2A, 1'b1, 64'd0, 64'h55, 1, 1'b0, 1'b1);
        run_txn(1'b1, 6'h2A, 1'b1, 64'd0, 64'h55, 1, 1'b0, 1'b0);
        run_txn(1'b0, 6'h07, 1'b0, 64'h77, 64'd0, 1, 1'b0, 1'b0);
        run_txn(1'b0, 6'h08, 1'b1, 64'd0, 64'h88, 1, 1'b0, 1'b0);
        run_txn(1'b0, 6'h03, 1'b1, 64'd0, 64'h9999, 0, 1'b0, 1'b0);
        run_txn(1'b0, 6'h03, 1'b1, 64'd0, 64'h9999, 5, 1'b0, 1'b1);
        run_txn(1'b1, 6'h03, 1'b1, 64'd0, 64'hCAFE_F00D, 305, 1'b0, 1'b0);
        run_txn(1'b1, 6'h0D, 1'b0, 64'h1, 64'd0, 1, 1'b0, 1'b0);
        run_txn(1'b0, 6'h05, 1'b0, 64'h0123_4567_89AB_CDEF, 64'd0, 2, 1'b1, 1'b0);
        run_txn(1'b0, 6'h03, 1'b1, 64'd0, 64'hABCD, 1, 1'b1, 1'b0);

        // Reset in the second ACCESS cycle.
        sel_b = 1'b0; addr = 6'h03; r_nw = 1'b1; wdata = 64'h1111; req = 1'b1; reg_ack = 1'b0;
        hot3 = 64'd0; hot3[3] = 1'b1;
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_access_dec", obs_rd, hot3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 64'(obs_busy), 64'd0);
        chk("rst_mid_outs", 64'(obs_ack) | 64'(obs_err) | obs_rdata | obs_rd | obs_wr, 64'd0);
        chk("rst_mid_wdata", obs_wdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_ack", 64'(obs_ack), 64'd0);
        chk("rst_mid_idle", 64'(obs_busy), 64'd0);

        // Random traffic on both configurations.
        for (int n = 0; n < 60; n++) begin
            run_txn(1'b0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 20; n++) begin
            run_txn(1'b1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom}, {$urandom, $urandom},
                    int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
